// File: rtl/median_pkg.sv
// Shared types and constants for the median filter window feeder.
package median_pkg;

  localparam int unsigned WINDOW_SIZE = 9;
  localparam int unsigned K_W         = $clog2(WINDOW_SIZE);

  // Neighbour offsets in row-major order, (-1,-1) first and (1,1) last.
  localparam int NB_DY [WINDOW_SIZE] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int NB_DX [WINDOW_SIZE] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

  // Border states only exist when border copying is built in.
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WAIT,
    S_WRITE,
`ifdef BORDER_COPY_EN
    S_BORDER_RD,
    S_BORDER_WR,
`else
    S_SKIP,
`endif
    S_FINISH
  } feeder_state_t;

  // Linear address offset of window tap k relative to the centre pixel.
  function automatic int nb_offset(input logic [K_W-1:0] k, input int img_w);
    return NB_DY[k] * img_w + NB_DX[k];
  endfunction

  // A pixel is interior when its full 3x3 neighbourhood lies inside the image.
  function automatic logic is_interior(input int unsigned x, input int unsigned y,
                                       input int unsigned w, input int unsigned h);
    return (x >= 1) && (x + 2 <= w) && (y >= 1) && (y + 2 <= h);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order pixel position tracker: x/y with wrap, last-pixel flag,
// interior classification of the next pixel and its linear base address.
// The base address y*IMG_W+x steps by one per pixel, so no multiplier.
module raster_counter
  import median_pkg::*;
#(
  parameter int unsigned IMG_W  = 16,
  parameter int unsigned IMG_H  = 16,
  parameter int unsigned ADDR_W = $clog2(IMG_W*IMG_H)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] base,
  output logic              last_c,
  output logic              nxt_interior_c,
  output logic [ADDR_W-1:0] nxt_base_c
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [XW-1:0] nxt_x;
  logic [YW-1:0] nxt_y;
  logic          x_last;
  logic          y_last;

  // Next raster position and its classification.
  always_comb begin
    x_last         = (x == XW'(IMG_W - 1));
    y_last         = (y == YW'(IMG_H - 1));
    last_c         = x_last && y_last;
    nxt_x          = x_last ? '0 : x + XW'(1);
    nxt_y          = x_last ? y + YW'(1) : y;
    nxt_base_c     = base + ADDR_W'(1);
    nxt_interior_c = is_interior(32'(nxt_x), 32'(nxt_y), IMG_W, IMG_H);
  end

  // Position registers; clear parks the scan at (0,0).
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      x    <= '0;
      y    <= '0;
      base <= '0;
    end else if (advance) begin
      x    <= nxt_x;
      y    <= nxt_y;
      base <= nxt_base_c;
    end
  end

endmodule

// File: rtl/median_window_feeder.sv
// Median filter window feeder: raster-scans the source image, streams each
// interior 3x3 window to the filter as nine contiguous DSI samples, waits
// for DSO and writes the median to the destination image.
// Build option: BORDER_COPY_EN copies border pixels unchanged; without it
// border pixels are skipped at one cycle each with no read or write.
// DI/DSI are registered from RDATA, so each sample leaves the block one
// cycle after the FETCH/DRAIN cycle in which its RAM word arrived.
module median_window_feeder
  import median_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned IMG_W  = 16,
  parameter int unsigned IMG_H  = 16,
  parameter int unsigned ADDR_W = $clog2(IMG_W*IMG_H)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] RADDR,
  input  logic [WIDTH-1:0]  RDATA,
  output logic [WIDTH-1:0]  DI,
  output logic              DSI,
  input  logic [WIDTH-1:0]  DO,
  input  logic              DSO,
  output logic              WE,
  output logic [ADDR_W-1:0] WADDR,
  output logic [WIDTH-1:0]  WDATA
);

  feeder_state_t     state, state_nxt;
  logic [K_W-1:0]    k, k_nxt;
  logic              busy_nxt, done_nxt, dsi_nxt, we_nxt;
  logic [WIDTH-1:0]  di_nxt, wdata_nxt;
  logic [ADDR_W-1:0] raddr_nxt, waddr_nxt;

  logic              cnt_clear, cnt_adv;
  logic [ADDR_W-1:0] base, nxt_base_c;
  logic              last_c, nxt_interior_c;

  logic              dispatch;
  logic              disp_interior;
  logic [ADDR_W-1:0] disp_base;

  // Source address of window tap kk around centre address b.
  function automatic logic [ADDR_W-1:0] win_addr(input logic [ADDR_W-1:0] b,
                                                 input logic [K_W-1:0]    kk);
    return ADDR_W'(int'(b) + nb_offset(kk, int'(IMG_W)));
  endfunction

  raster_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_raster (
    .CLK            (CLK),
    .RST            (RST),
    .clear          (cnt_clear),
    .advance        (cnt_adv),
    .base           (base),
    .last_c         (last_c),
    .nxt_interior_c (nxt_interior_c),
    .nxt_base_c     (nxt_base_c)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_nxt     = state;
    k_nxt         = k;
    busy_nxt      = BUSY;
    done_nxt      = 1'b0;
    dsi_nxt       = 1'b0;
    di_nxt        = DI;
    we_nxt        = 1'b0;
    raddr_nxt     = RADDR;
    waddr_nxt     = WADDR;
    wdata_nxt     = WDATA;
    cnt_clear     = 1'b0;
    cnt_adv       = 1'b0;
    dispatch      = 1'b0;
    disp_interior = nxt_interior_c;
    disp_base     = nxt_base_c;

    case (state)
      S_IDLE: begin
        if (START) begin
          busy_nxt      = 1'b1;
          cnt_clear     = 1'b1;
          dispatch      = 1'b1;
          disp_interior = 1'b0;
          disp_base     = '0;
        end
      end
      S_FETCH: begin
        if (k != '0) begin
          dsi_nxt = 1'b1;
          di_nxt  = RDATA;
        end
        if (k == K_W'(WINDOW_SIZE - 1)) begin
          state_nxt = S_DRAIN;
        end else begin
          k_nxt     = k + K_W'(1);
          raddr_nxt = win_addr(base, k + K_W'(1));
        end
      end
      S_DRAIN: begin
        dsi_nxt   = 1'b1;
        di_nxt    = RDATA;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (DSO) begin
          we_nxt    = 1'b1;
          waddr_nxt = base;
          wdata_nxt = DO;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (last_c) begin
          state_nxt = S_FINISH;
        end else begin
          cnt_adv  = 1'b1;
          dispatch = 1'b1;
        end
      end
`ifdef BORDER_COPY_EN
      S_BORDER_RD: begin
        state_nxt = S_BORDER_WR;
      end
      S_BORDER_WR: begin
        we_nxt    = 1'b1;
        waddr_nxt = base;
        wdata_nxt = RDATA;
        if (last_c) begin
          state_nxt = S_FINISH;
        end else begin
          cnt_adv  = 1'b1;
          dispatch = 1'b1;
        end
      end
`else
      S_SKIP: begin
        if (last_c) begin
          state_nxt = S_FINISH;
        end else begin
          cnt_adv  = 1'b1;
          dispatch = 1'b1;
        end
      end
`endif
      S_FINISH: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Route the pixel about to be processed to the window or border path.
    if (dispatch) begin
      if (disp_interior) begin
        state_nxt = S_FETCH;
        k_nxt     = '0;
        raddr_nxt = win_addr(disp_base, '0);
      end else begin
`ifdef BORDER_COPY_EN
        state_nxt = S_BORDER_RD;
        raddr_nxt = disp_base;
`else
        state_nxt = S_SKIP;
`endif
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      k     <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      DSI   <= 1'b0;
      DI    <= '0;
      WE    <= 1'b0;
      RADDR <= '0;
      WADDR <= '0;
      WDATA <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      BUSY  <= busy_nxt;
      DONE  <= done_nxt;
      DSI   <= dsi_nxt;
      DI    <= di_nxt;
      WE    <= we_nxt;
      RADDR <= raddr_nxt;
      WADDR <= waddr_nxt;
      WDATA <= wdata_nxt;
    end
  end

endmodule

// File: tb/tb_median_window_feeder.sv
// Bench for median_window_feeder on a 4x4 image with a behavioural median
// filter, a synchronous source RAM and a destination image scoreboard.
module tb_median_window_feeder;

  localparam int W    = 8;
  localparam int IW   = 4;
  localparam int IH   = 4;
  localparam int AW   = 4;
  localparam int NPIX = IW * IH;
  localparam int RH   = 512;
`ifdef BORDER_COPY_EN
  localparam bit COPY = 1'b1;
`else
  localparam bit COPY = 1'b0;
`endif
  localparam int EXP_WE  = COPY ? 16 : 4;
  localparam int EXP_BWE = COPY ? 12 : 0;

  typedef logic [W-1:0] win_t [9];

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic          BUSY, DONE, DSI, WE, DSO;
  logic [AW-1:0] RADDR, WADDR;
  logic [W-1:0]  RDATA, DI, DO, WDATA;

  logic [W-1:0]  src [NPIX];
  logic [W-1:0]  dst [NPIX];
  logic          model_dso = 1'b0;
  logic          inj_dso;
  int            lat;
  int            frame_id;
  int            nvec = 0;
  int            nfail = 0;

  // monitor-owned
  int            seen_id = 0;
  int            we_cnt, bwe_cnt, done_cnt, fw_n, rh_n;
  logic [W-1:0]  first_win [9];
  logic [AW-1:0] raddr_hist [RH];

  // filter-model-owned
  int            gap_err = 0;

  always #5 CLK = ~CLK;

  assign DSO = model_dso | inj_dso;

  median_window_feeder #(
    .WIDTH (W), .IMG_W (IW), .IMG_H (IH), .ADDR_W (AW)
  ) dut (
    .CLK (CLK), .RST (RST), .START (START), .BUSY (BUSY), .DONE (DONE),
    .RADDR (RADDR), .RDATA (RDATA), .DI (DI), .DSI (DSI),
    .DO (DO), .DSO (DSO), .WE (WE), .WADDR (WADDR), .WDATA (WDATA)
  );

  // synchronous source RAM
  always @(posedge CLK) RDATA <= src[RADDR];

  function automatic logic [W-1:0] med9(input win_t w);
    logic [W-1:0] a [9];
    logic [W-1:0] t;
    for (int i = 0; i < 9; i++) a[i] = w[i];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    return a[4];
  endfunction

  function automatic bit is_int(input int a);
    int x, y;
    x = a % IW;
    y = a / IW;
    return (x >= 1) && (x <= IW - 2) && (y >= 1) && (y <= IH - 2);
  endfunction

  function automatic int ref_pix(input int a);
    win_t w;
    int x, y, j;
    x = a % IW;
    y = a / IW;
    if (!is_int(a)) return COPY ? int'(src[a]) : 'hEE;
    j = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        w[j] = src[(y + dy) * IW + x + dx];
        j++;
      end
    return int'(med9(w));
  endfunction

  function automatic int vv(input logic [31:0] s);
    return $isunknown(s) ? -1 : int'(s);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural filter: collects nine contiguous samples, answers after lat cycles.
  initial begin : filter_model
    win_t samp;
    int   cnt, timer;
    bit   pend;
    logic [W-1:0] med;
    cnt = 0; pend = 0; timer = 0; med = '0; DO = '0;
    forever begin
      @(negedge CLK);
      model_dso = 1'b0;
      if (RST === 1'b1) begin
        cnt = 0; pend = 0;
      end else begin
        if (pend) begin
          if (timer <= 1) begin model_dso = 1'b1; DO = med; pend = 0; end
          else timer--;
        end
        if (DSI === 1'b1) begin
          if (pend) gap_err++;
          samp[cnt] = DI;
          cnt++;
          if (cnt == 9) begin med = med9(samp); pend = 1; timer = lat; cnt = 0; end
        end else if (cnt != 0) begin
          gap_err++;
          cnt = 0;
        end
      end
    end
  end

  // Destination RAM image plus per-frame event counters.
  initial begin : monitor
    we_cnt = 0; bwe_cnt = 0; done_cnt = 0; fw_n = 0; rh_n = 0;
    forever begin
      @(negedge CLK);
      if (frame_id != seen_id) begin
        seen_id = frame_id;
        for (int a = 0; a < NPIX; a++) dst[a] = 8'hEE;
        we_cnt = 0; bwe_cnt = 0; done_cnt = 0; fw_n = 0; rh_n = 0;
      end
      if (rh_n < RH) begin raddr_hist[rh_n] = RADDR; rh_n++; end
      if (WE === 1'b1) begin
        dst[WADDR] = WDATA;
        we_cnt++;
        if (!is_int(int'(WADDR))) bwe_cnt++;
      end
      if (DONE === 1'b1) done_cnt++;
      if (DSI === 1'b1 && fw_n < 9) begin first_win[fw_n] = DI; fw_n++; end
    end
  end

  task automatic fill_src(input int pat);
    for (int a = 0; a < NPIX; a++)
      case (pat)
        0:       src[a] = 8'h55;
        1:       src[a] = 8'(a);
        2:       src[a] = (a == 5) ? 8'hFF : 8'h00;
        default: src[a] = 8'((a * 37 + 11) & 255);
      endcase
  endtask

  // One START..DONE frame; optionally re-pulses START once mid-window.
  task automatic run_frame(input int l, input bit restart, output int tmo, output int busy_bad);
    bit restarted;
    lat = l;
    restarted = 0;
    busy_bad = 0;
    tmo = 1;
    @(negedge CLK);
    frame_id++;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (DONE === 1'b1) begin tmo = 0; break; end
      if (BUSY !== 1'b1) busy_bad++;
      if (restart && !restarted && DSI === 1'b1) begin START = 1'b1; restarted = 1; end
      else START = 1'b0;
      @(negedge CLK);
    end
    START = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (BUSY !== 1'b0) busy_bad++;
    end
  endtask

  task automatic check_frame(input string tag, input int tmo, input int busy_bad,
                             input int gap0, input int exp_we, input int exp_bwe);
    chk({tag, "_timeout"}, tmo, 0);
    chk({tag, "_busy"}, busy_bad, 0);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_we_cnt"}, we_cnt, exp_we);
    chk({tag, "_border_we"}, bwe_cnt, exp_bwe);
    chk({tag, "_dsi_gap"}, gap_err - gap0, 0);
    for (int a = 0; a < NPIX; a++)
      chk($sformatf("%s_pix%0d", tag, a), vv(32'(dst[a])), ref_pix(a));
  endtask

  typedef struct {
    int pat;
    int lat;
    bit restart;
    int exp_we;
    int exp_bwe;
  } vec_t;

  initial begin : main
    vec_t vecs [5];
    int   tmo, bb, gap0, w0, found;
    logic [AW-1:0] exp_ra [9];
    int   exp_win [9];

    vecs[0] = '{0, 41, 1'b0, EXP_WE, EXP_BWE};
    vecs[1] = '{1, 3,  1'b0, EXP_WE, EXP_BWE};
    vecs[2] = '{2, 5,  1'b0, EXP_WE, EXP_BWE};
    vecs[3] = '{3, 1,  1'b0, EXP_WE, EXP_BWE};
    vecs[4] = '{3, 2,  1'b1, EXP_WE, EXP_BWE};
    exp_win = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    for (int j = 0; j < 9; j++) exp_ra[j] = AW'(exp_win[j]);

    RST = 1'b1; START = 1'b0; inj_dso = 1'b0; lat = 4; frame_id = 0;
    fill_src(0);
    repeat (3) @(negedge CLK);
    chk("rst_busy", vv(32'(BUSY)), 0);
    chk("rst_done", vv(32'(DONE)), 0);
    chk("rst_dsi", vv(32'(DSI)), 0);
    chk("rst_di", vv(32'(DI)), 0);
    chk("rst_we", vv(32'(WE)), 0);
    chk("rst_raddr", vv(32'(RADDR)), 0);
    chk("rst_waddr", vv(32'(WADDR)), 0);
    chk("rst_wdata", vv(32'(WDATA)), 0);
    RST = 1'b0;

    for (int v = 0; v < 5; v++) begin
      fill_src(vecs[v].pat);
      gap0 = gap_err;
      run_frame(vecs[v].lat, vecs[v].restart, tmo, bb);
      check_frame($sformatf("vec%0d", v), tmo, bb, gap0, vecs[v].exp_we, vecs[v].exp_bwe);
      if (vecs[v].pat == 1) begin
        for (int j = 0; j < 9; j++)
          chk($sformatf("win_di%0d", j), vv(32'(first_win[j])), exp_win[j]);
        found = 0;
        for (int i = 0; i + 9 <= rh_n; i++) begin
          bit m;
          m = 1;
          for (int j = 0; j < 9; j++) if (raddr_hist[i+j] !== exp_ra[j]) m = 0;
          if (m) found = 1;
        end
        chk("win_raddr_seq", found, 1);
      end
    end

    // Reset while waiting on the filter for pixel (1,1), then a stray DSO.
    fill_src(3);
    lat = 100000;
    @(negedge CLK);
    frame_id++;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    tmo = 1;
    for (int i = 0; i < 300; i++) begin
      if (fw_n == 9 && DSI === 1'b0) begin tmo = 0; break; end
      @(negedge CLK);
    end
    chk("wait_reach_timeout", tmo, 0);
    repeat (3) @(negedge CLK);
    w0 = we_cnt;
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_busy", vv(32'(BUSY)), 0);
    chk("mid_rst_done", vv(32'(DONE)), 0);
    chk("mid_rst_dsi", vv(32'(DSI)), 0);
    chk("mid_rst_di", vv(32'(DI)), 0);
    chk("mid_rst_we", vv(32'(WE)), 0);
    chk("mid_rst_raddr", vv(32'(RADDR)), 0);
    chk("mid_rst_waddr", vv(32'(WADDR)), 0);
    chk("mid_rst_wdata", vv(32'(WDATA)), 0);
    RST = 1'b0;
    @(negedge CLK);
    inj_dso = 1'b1;
    @(negedge CLK);
    inj_dso = 1'b0;
    repeat (10) @(negedge CLK);
    chk("stray_dso_we", we_cnt, w0);
    chk("stray_dso_busy", vv(32'(BUSY)), 0);
    chk("stray_dso_done", done_cnt, 0);
    chk("stray_dso_waddr", vv(32'(WADDR)), 0);

    // A fresh START after the reset runs a complete frame.
    gap0 = gap_err;
    run_frame(6, 1'b0, tmo, bb);
    check_frame("post_rst", tmo, bb, gap0, EXP_WE, EXP_BWE);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/median_window_feeder.md
# median_window_feeder

Initiator side of the median filter stream interface. Scans a greyscale image held in a synchronous RAM in raster order, streams the 3×3 neighbourhood of each interior pixel to the median filter as 9 consecutive DSI-qualified samples, and waits for the filter's DSO pulse. It then writes the returned median to the output image memory. It sits between the image RAMs and the median filter, under control of a top-level START/DONE handshake.

## Interface
- WIDTH, 8: pixel width in bits
- IMG_W, 16: image width in pixels (≥3)
- IMG_H, 16: image height in pixels (≥3)
- ADDR_W, $clog2(IMG_W*IMG_H): pixel address width

- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  start pulse; sampled only in IDLE
- BUSY  out  1  high from the cycle after START is accepted until DONE
- DONE  out  1  one-cycle pulse after the last write
- RADDR  out  ADDR_W  source RAM read address
- RDATA  in  WIDTH  source RAM data, valid 1 cycle after RADDR
- DI  out  WIDTH  sample to median filter
- DSI  out  1  sample strobe; high for exactly 9 consecutive cycles per window
- DO  in  WIDTH  median result
- DSO  in  1  one-cycle result-valid pulse from the filter
- WE  out  1  destination RAM write enable
- WADDR  out  ADDR_W  destination address = y*IMG_W + x
- WDATA  out  WIDTH  destination data

## Operation
- States: IDLE, FETCH, DRAIN, WAIT, WRITE, BORDER_RD, BORDER_WR, FINISH.
- IDLE: START=1 → load (x,y)=(0,0), go to the state for that pixel. START in any other state is ignored.
- Pixel dispatch: interior (1≤x≤IMG_W-2, 1≤y≤IMG_H-2) → FETCH. Border → BORDER_RD.
- FETCH: 9 cycles, k=0..8. RADDR = (y+dy)*IMG_W + (x+dx), with (dy,dx) in row-major order (-1,-1),(-1,0),(-1,1),(0,-1),…,(1,1). Then → DRAIN.
- DSI/DI: DSI=1 and DI=RDATA in cycles k=1..8 of FETCH and in DRAIN, so the 9 samples are contiguous. DSI=0 everywhere else.
- DRAIN: 1 cycle → WAIT.
- WAIT: hold until DSO=1. Capture DO into WDATA and set WADDR, then → WRITE. No timeout.
- WRITE: WE=1 for one cycle, then advance the pixel.
- BORDER_RD: RADDR = own address. BORDER_WR: WE=1, WDATA=RDATA. Then advance.
- Advance: x+1. At x=IMG_W-1, wrap x=0 and y+1. After (IMG_W-1, IMG_H-1) → FINISH.
- FINISH: DONE=1 for 1 cycle, BUSY=0, → IDLE.
- Address arithmetic is unsigned ADDR_W bits. Interior neighbour addresses never underflow because of the dispatch rule.
- DSO outside WAIT is ignored.

## Timing
- Reset values: BUSY=0, DONE=0, DSI=0, DI=0, WE=0, RADDR=0, WADDR=0, WDATA=0; state IDLE.
- All outputs are registered.
- Interior pixel cost: 9 (FETCH) + 1 (DRAIN) + L (filter latency, cycles from last DSI to DSO, inclusive of WAIT) + 1 (WRITE).
- Between DSO and the next DSI rise there is at least 1 cycle with DSI=0: WRITE plus the FETCH k=0 cycle give 2.
- Border pixel cost: 2 cycles.
- RST mid-operation: the next cycle matches the reset values. A DSO arriving later is ignored. The filter must be reset by the same top-level reset.

## Configuration
- BORDER_COPY_EN defined: border pixels are copied unchanged via BORDER_RD/BORDER_WR.
- BORDER_COPY_EN undefined: the BORDER states are not compiled. Border pixels are skipped with no WE and no reads. Advance still takes 1 cycle per border pixel, and the destination border is left untouched.

## Structure
- Shared package median_pkg:
  - feeder_state_t enum.
  - WINDOW_SIZE=9 constant.
  - Neighbour offset constants.
- Sub-module raster_counter:
  - x/y counters with wrap and last-pixel flag.
  - Interior/border classification.
  - Base address y*IMG_W+x, maintained incrementally (no multiplier).

## Test plan
- IMG_W=IMG_H=4, source all 0x55, behavioural median model with L=41: exactly 4 interior WE, all WDATA=0x55. DONE once. BUSY high throughout.
- Window order at (1,1), IMG_W=4: RADDR sequence 0,1,2,4,5,6,8,9,10. DSI high 9 consecutive cycles, with DI equal to those RAM words in order.
- Impulse: 5×5 zeros with 0xFF at (2,2) and a real median filter: every interior WDATA=0x00.
- BORDER_COPY_EN on, 4×4 ramp p=addr: 12 border writes with WDATA=WADDR. BORDER_COPY_EN off: 0 border writes, 4 total WE.
- Assert RST during WAIT of pixel (1,1), then pulse DSO: no WE, outputs at reset values. A new START then completes normally.
- Pulse START again during FETCH: ignored; exactly one DONE per accepted START.
